// File: rtl/regbank_port_scheduler.sv
// Register-bank front end: post-reset clear sweep, round-robin read-port arbitration, write port with RAW stall.
// Define REGBANK_SCHED_PERF_EN to add the perf_grant_cnt / perf_stall_cnt counters.
module regbank_port_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int LANES    = 8,
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 64,
    parameter int ADDR_W   = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LANES-1:0]  req_mask,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wr_valid,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [LANES-1:0]          wr_mask,
    input  logic [LANES*DATA_W-1:0]   wr_data,
    output logic                      wr_ready,
    output logic [LANES-1:0]          rb_read_en_0,
    output logic [LANES-1:0]          rb_read_en_1,
    output logic [ADDR_W-1:0]         rb_raddr_0,
    output logic [ADDR_W-1:0]         rb_raddr_1,
    input  logic [LANES*DATA_W-1:0]   rb_rdata_0,
    input  logic [LANES*DATA_W-1:0]   rb_rdata_1,
    output logic [LANES-1:0]          rb_write_en,
    output logic [ADDR_W-1:0]         rb_waddr,
    output logic [LANES*DATA_W-1:0]   rb_wdata,
    output logic                      rsp0_valid,
    output logic                      rsp1_valid,
    output logic [2:0]                rsp0_id,
    output logic [2:0]                rsp1_id,
    output logic [LANES*DATA_W-1:0]   rsp0_data,
    output logic [LANES*DATA_W-1:0]   rsp1_data,
    output logic                      init_done
`ifdef REGBANK_SCHED_PERF_EN
    ,
    output logic [31:0]               perf_grant_cnt,
    output logic [31:0]               perf_stall_cnt
`endif
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    logic [0:0]         state;
    logic [ADDR_W-1:0]  clr_cnt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] eligible;
    logic               g0_vld, g1_vld;
    logic [PTR_W-1:0]   g0_idx, g1_idx, cand;
    logic [LANES-1:0]   g0_mask, g1_mask;
    logic [ADDR_W-1:0]  g0_addr, g1_addr;

    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= NUM_REQ) s -= NUM_REQ;
        return PTR_W'(s);
    endfunction

    function automatic logic [LANES*DATA_W-1:0] lane_expand(input logic [LANES-1:0] m);
        logic [LANES*DATA_W-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*DATA_W +: DATA_W] = {DATA_W{m[k]}};
        return r;
    endfunction

    // A read colliding with this cycle's write would see stale data, so it waits one cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = (state == ST_RUN) && req_valid[i] &&
                          !(wr_valid && (req_addr[i*ADDR_W +: ADDR_W] == wr_addr));
        end
    end

    // NOTE: every variable of this block is assigned a default first, so no path can infer a latch.
    always_comb begin
        g0_vld    = 1'b0;
        g1_vld    = 1'b0;
        g0_idx    = '0;
        g1_idx    = '0;
        cand      = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr_idx(rr_ptr, k);
            if (eligible[cand]) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_idx = cand;
                end else if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = cand;
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (g0_vld && (g0_idx == PTR_W'(i))) || (g1_vld && (g1_idx == PTR_W'(i)));
        end
    end

    assign g0_mask = req_mask[g0_idx*LANES +: LANES];
    assign g1_mask = req_mask[g1_idx*LANES +: LANES];
    assign g0_addr = req_addr[g0_idx*ADDR_W +: ADDR_W];
    assign g1_addr = req_addr[g1_idx*ADDR_W +: ADDR_W];

    assign rb_read_en_0 = g0_vld ? g0_mask : '0;
    assign rb_read_en_1 = g1_vld ? g1_mask : '0;
    assign rb_raddr_0   = g0_vld ? g0_addr : '0;
    assign rb_raddr_1   = g1_vld ? g1_addr : '0;

    always_comb begin
        wr_ready = (state == ST_RUN);
        if (state == ST_INIT) begin
            rb_write_en = '1;
            rb_waddr    = clr_cnt;
            rb_wdata    = '0;
        end else begin
            rb_write_en = wr_valid ? wr_mask : '0;
            rb_waddr    = wr_addr;
            rb_wdata    = wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            clr_cnt    <= '0;
            init_done  <= 1'b0;
            rr_ptr     <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_id    <= '0;
            rsp1_id    <= '0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                // NOTE: the bank storage has no reset pins; this sweep is what zeroes it.
                ST_INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_REG) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    if (g0_vld) begin
                        rsp0_valid <= 1'b1;
                        rsp0_id    <= 3'(g0_idx);
                        rsp0_data  <= rb_rdata_0 & lane_expand(g0_mask);
                    end
                    if (g1_vld) begin
                        rsp1_valid <= 1'b1;
                        rsp1_id    <= 3'(g1_idx);
                        rsp1_data  <= rb_rdata_1 & lane_expand(g1_mask);
                    end
                    if (g1_vld)      rr_ptr <= rr_idx(g1_idx, 1);
                    else if (g0_vld) rr_ptr <= rr_idx(g0_idx, 1);
                end
            endcase
        end
    end

`ifdef REGBANK_SCHED_PERF_EN
    logic [1:0] grant_num;
    logic       stall;
    assign grant_num = {1'b0, g0_vld} + {1'b0, g1_vld};
    assign stall     = (state == ST_RUN) && ((req_valid & ~req_ready) != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else if (state == ST_RUN) begin
            if (perf_grant_cnt > (32'hFFFF_FFFF - 32'(grant_num))) perf_grant_cnt <= '1;
            else perf_grant_cnt <= perf_grant_cnt + 32'(grant_num);
            if (stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
`endif

endmodule
